alu_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined successor to the 8-bit combinational ALU.

---
 rtl/alu_pipe.sv | 194 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the request and S2 registers the result that drives out_*.
// The EQ compare state lives between the stages. It is updated when an op
// moves S1->S2, so an EQ followed by a BEQ sees the new value.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              co_flag,
    output logic              eq_flag,
    output logic              branch_flag,
    output logic              taken
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_EQ  = 3'b110;
    localparam logic [2:0] OP_BEQ = 3'b111;

    typedef struct packed {
        logic             co;
        logic             eq;
        logic             br;
        logic             tk;
        logic [WIDTH-1:0] data;
    } res_t;

    // Result of one op. Arithmetic is done one bit wider so the top bit is carry/borrow.
    function automatic res_t alu_eval(input logic [2:0]        op_i,
                                      input logic [WIDTH-1:0]  a_i,
                                      input logic [WIDTH-1:0]  b_i,
                                      input logic [ADDR_W-1:0] addr_i,
                                      input logic              eq_st);
        res_t           r;
        logic [WIDTH:0] wide;
        r    = '0;
        wide = '0;
        case (op_i)
            OP_ADD: begin
                wide   = {1'b0, a_i} + {1'b0, b_i};
                r.data = wide[WIDTH-1:0];
                r.co   = wide[WIDTH];
            end
            OP_SUB: begin
                wide   = {1'b0, a_i} - {1'b0, b_i};
                r.data = wide[WIDTH-1:0];
                r.co   = wide[WIDTH];
            end
            OP_AND: r.data = a_i & b_i;
            OP_NOT: r.data = ~a_i;
            OP_OR:  r.data = a_i | b_i;
            OP_EQ: begin
                r.eq   = (a_i == b_i);
                r.data = WIDTH'(r.eq);
            end
            OP_BEQ: begin
                r.br = 1'b1;
                r.tk = eq_st;
                if (eq_st) begin
                    r.data = WIDTH'(addr_i);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [2:0]        s1_op_q, s1_op_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              co_q, co_d;
    logic              eq_flag_q, eq_flag_d;
    logic              br_q, br_d;
    logic              taken_q, taken_d;
    logic              eq_state_q, eq_state_d;

    logic              accept;
    logic              adv1;
    logic              adv2;
    res_t              s1_res;

    assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign adv1     = s1_valid_q && (!s2_valid_q || out_ready);
    assign adv2     = s2_valid_q && out_ready;

    // Evaluate the op held in S1 against the current compare state.
    always_comb begin
        s1_res = alu_eval(s1_op_q, s1_a_q, s1_b_q, s1_addr_q, eq_state_q);
    end

    // S1 next state: load on accept, empty when its op moves on, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_addr_d  = s1_addr_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = op;
            s1_addr_d  = branch_addr;
        end else if (adv1) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state and compare state. Both change only when an op moves S1->S2.
    always_comb begin
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        co_d       = co_q;
        eq_flag_d  = eq_flag_q;
        br_d       = br_q;
        taken_d    = taken_q;
        eq_state_d = eq_state_q;
        if (adv1) begin
            s2_valid_d = 1'b1;
            out_data_d = s1_res.data;
            co_d       = s1_res.co;
            eq_flag_d  = s1_res.eq;
            br_d       = s1_res.br;
            taken_d    = s1_res.tk;
            if (s1_op_q == OP_EQ) begin
                eq_state_d = s1_res.eq;
            end else if (s1_op_q == OP_BEQ) begin
                eq_state_d = 1'b0;
            end
        end else if (adv2) begin
            s2_valid_d = 1'b0;
        end
    end

    // Control, compare state and visible outputs; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            eq_state_q <= 1'b0;
            out_data_q <= '0;
            co_q       <= 1'b0;
            eq_flag_q  <= 1'b0;
            br_q       <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            eq_state_q <= eq_state_d;
            out_data_q <= out_data_d;
            co_q       <= co_d;
            eq_flag_q  <= eq_flag_d;
            br_q       <= br_d;
            taken_q    <= taken_d;
        end
    end

    // S1 operand payload; it is only read while s1_valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_op_q   <= s1_op_d;
        s1_addr_q <= s1_addr_d;
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = out_data_q;
    assign co_flag     = co_q;
    assign eq_flag     = eq_flag_q;
    assign branch_flag = br_q;
    assign taken       = taken_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for the pipelined ALU at WIDTH=8 and WIDTH=16.
module tb_alu_pipe;

    localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011;
    localparam logic [2:0] NOT_ = 3'b100, OR_ = 3'b101, EQ = 3'b110, BEQ = 3'b111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] op;
    logic [7:0] a, b, out_data;
    logic [5:0] branch_addr;
    logic       co_flag, eq_flag, branch_flag, taken;

    alu_pipe #(.WIDTH(8), .ADDR_W(6)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .branch_addr(branch_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .co_flag(co_flag),
        .eq_flag(eq_flag), .branch_flag(branch_flag), .taken(taken)
    );

    // 16-bit instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, out_data16;
    logic [9:0]  addr16;
    logic        co16, eq16, br16, tk16;

    alu_pipe #(.WIDTH(16), .ADDR_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .branch_addr(addr16), .out_valid(out_valid16),
        .out_ready(out_ready16), .out_data(out_data16), .co_flag(co16),
        .eq_flag(eq16), .branch_flag(br16), .taken(tk16)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] addr;
        logic [7:0] d;
        logic       co;
        logic       eq;
        logic       br;
        logic       tk;
    } vec_t;

    vec_t expq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // values sampled by the most recent tick
    logic       s_ov, s_ir;
    logic [7:0] s_data;
    logic [3:0] s_flags;
    logic       stall_prev = 1'b0;
    logic [7:0] held_data;
    logic [3:0] held_flags;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: sample at negedge, check any delivered result and stall stability.
    task automatic tick();
        vec_t e;
        @(negedge clk);
        s_ov    = out_valid;
        s_ir    = in_ready;
        s_data  = out_data;
        s_flags = {co_flag, eq_flag, branch_flag, taken};
        if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(held_data));
            chk("stall_flags", 32'(s_flags), 32'(held_flags));
        end
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("flags{co,eq,br,tk}", 32'(s_flags), 32'({e.co, e.eq, e.br, e.tk}));
            end
        end
        stall_prev = out_valid && !out_ready && !rst;
        held_data  = out_data;
        held_flags = s_flags;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        bit acc = 0;
        in_valid    = 1'b1;
        op          = v.op;
        a           = v.a;
        b           = v.b;
        branch_addr = v.addr;
        expq.push_back(v);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_ir) begin
                acc = 1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && expq.size() > 0; k++) tick();
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                                input logic [5:0] ad, input logic [7:0] d,
                                input logic co, input logic eq, input logic br, input logic tk);
        vec_t v;
        v.op = o; v.a = ai; v.b = bi; v.addr = ad; v.d = d;
        v.co = co; v.eq = eq; v.br = br; v.tk = tk;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(ADD,  8'hFF, 8'h01, 6'h00, 8'h00, 1, 0, 0, 0);
        tbl[1]  = mk(SUB,  8'h03, 8'h05, 6'h00, 8'hFE, 1, 0, 0, 0);
        tbl[2]  = mk(ADD,  8'h12, 8'h34, 6'h00, 8'h46, 0, 0, 0, 0);
        tbl[3]  = mk(SUB,  8'h05, 8'h03, 6'h00, 8'h02, 0, 0, 0, 0);
        tbl[4]  = mk(SUB,  8'h07, 8'h07, 6'h00, 8'h00, 0, 0, 0, 0);
        tbl[5]  = mk(AND_, 8'hF0, 8'h3C, 6'h00, 8'h30, 0, 0, 0, 0);
        tbl[6]  = mk(OR_,  8'hF0, 8'h0C, 6'h00, 8'hFC, 0, 0, 0, 0);
        tbl[7]  = mk(NOT_, 8'h5A, 8'hFF, 6'h00, 8'hA5, 0, 0, 0, 0);
        tbl[8]  = mk(NOP,  8'hFF, 8'hFF, 6'h3F, 8'h00, 0, 0, 0, 0);
        tbl[9]  = mk(EQ,   8'h5A, 8'h5A, 6'h00, 8'h01, 0, 1, 0, 0);
        tbl[10] = mk(BEQ,  8'h00, 8'h01, 6'h3F, 8'h3F, 0, 0, 1, 1);
        tbl[11] = mk(BEQ,  8'h00, 8'h00, 6'h3F, 8'h00, 0, 0, 1, 0);
        tbl[12] = mk(EQ,   8'h01, 8'h02, 6'h00, 8'h00, 0, 0, 0, 0);
        tbl[13] = mk(ADD,  8'h80, 8'h80, 6'h00, 8'h00, 1, 0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = NOP; a = '0; b = '0; branch_addr = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = NOP; a16 = '0; b16 = '0; addr16 = '0;
        tick();
        tick();
        chk("in_ready_in_reset", 32'(s_ir), 32'd0);
        rst = 1'b0;
        tick();
        chk("reset_out_valid", 32'(s_ov), 32'd0);
        chk("reset_out_data", 32'(s_data), 32'd0);
        chk("reset_flags", 32'(s_flags), 32'd0);
        chk("reset_in_ready", 32'(s_ir), 32'd1);

        // ADD with carry and the two-cycle latency
        send(mk(ADD, 8'hFF, 8'h01, 6'h00, 8'h00, 1, 0, 0, 0));
        tick();
        chk("latency_cycle1_valid", 32'(s_ov), 32'd0);
        tick();
        chk("latency_cycle2_valid", 32'(s_ov), 32'd1);
        send(mk(SUB, 8'h03, 8'h05, 6'h00, 8'hFE, 1, 0, 0, 0));
        drain();

        // vector table, back-to-back
        foreach (tbl[i]) send(tbl[i]);
        drain();

        // EQ match then BEQ on the next cycle, then a second BEQ
        send(mk(EQ,  8'h5A, 8'h5A, 6'h00, 8'h01, 0, 1, 0, 0));
        send(mk(BEQ, 8'h00, 8'h00, 6'h2A, 8'h2A, 0, 0, 1, 1));
        send(mk(BEQ, 8'h00, 8'h00, 6'h2A, 8'h00, 0, 0, 1, 0));
        drain();

        // EQ mismatch, AND, BEQ
        send(mk(EQ,   8'h10, 8'h11, 6'h00, 8'h00, 0, 0, 0, 0));
        send(mk(AND_, 8'h10, 8'h11, 6'h00, 8'h10, 0, 0, 0, 0));
        send(mk(BEQ,  8'h00, 8'h00, 6'h15, 8'h00, 0, 0, 1, 0));
        drain();

        // six ADDs with a three-cycle output stall in the middle
        send(mk(ADD, 8'd1, 8'd10, 6'h00, 8'd11, 0, 0, 0, 0));
        send(mk(ADD, 8'd2, 8'd20, 6'h00, 8'd22, 0, 0, 0, 0));
        out_ready = 1'b0;
        in_valid = 1'b1; op = ADD; a = 8'd3; b = 8'd30;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("in_ready_when_full", 32'(s_ir), 32'd0);
        end
        out_ready = 1'b1;
        send(mk(ADD, 8'd3, 8'd30, 6'h00, 8'd33, 0, 0, 0, 0));
        send(mk(ADD, 8'd4, 8'd40, 6'h00, 8'd44, 0, 0, 0, 0));
        send(mk(ADD, 8'd5, 8'd50, 6'h00, 8'd55, 0, 0, 0, 0));
        send(mk(ADD, 8'hF0, 8'h20, 6'h00, 8'h10, 1, 0, 0, 0));
        drain();

        // reset with two ops in flight and compare state set
        send(mk(EQ, 8'h33, 8'h33, 6'h00, 8'h01, 0, 1, 0, 0));
        tick();
        out_ready = 1'b0;
        send(mk(ADD, 8'h01, 8'h01, 6'h00, 8'h02, 0, 0, 0, 0));
        expq.delete();
        rst = 1'b1;
        tick();
        chk("in_ready_mid_reset", 32'(s_ir), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_reset_valid", 32'(s_ov), 32'd0);
        chk("post_reset_flags", 32'(s_flags), 32'd0);
        send(mk(BEQ, 8'h00, 8'h00, 6'h15, 8'h00, 0, 0, 1, 0));
        drain();

        // 16-bit instance: ADD carry, EQ match, BEQ with a 10-bit address
        op16 = ADD; a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
        @(negedge clk);
        chk("w16_in_ready", 32'(in_ready16), 32'd1);
        @(posedge clk); #1;
        op16 = EQ; a16 = 16'h1234; b16 = 16'h1234;
        @(negedge clk);
        chk("w16_latency_valid", 32'(out_valid16), 32'd0);
        @(posedge clk); #1;
        op16 = BEQ; a16 = '0; b16 = '0; addr16 = 10'h2AB;
        @(negedge clk);
        chk("w16_add_valid", 32'(out_valid16), 32'd1);
        chk("w16_add_data", 32'(out_data16), 32'h0000);
        chk("w16_add_co", 32'(co16), 32'd1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(negedge clk);
        chk("w16_eq_data", 32'(out_data16), 32'h0001);
        chk("w16_eq_flag", 32'(eq16), 32'd1);
        @(negedge clk);
        chk("w16_beq_data", 32'(out_data16), 32'h02AB);
        chk("w16_beq_flags", 32'({co16, eq16, br16, tk16}), 32'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
